// File: rtl/fc_layer_tm.sv
// Time-multiplexed FP16 fully connected layer.
// PAR lanes share one weight ROM word per cycle. Each lane runs a serial MAC over the
// input channels for one neuron of the current group. After the last channel, the
// bias add and the optional ReLU write the results of that group into the output
// vector, and the engine moves on to the next group of PAR neurons.
module fc_layer_tm #(
    parameter int DATA_WIDTH     = 16,
    parameter int input_channel  = 120,
    parameter int output_channel = 84,
    parameter int PAR            = 4,
    parameter int RELU           = 0,
    localparam int G             = (output_channel + PAR - 1) / PAR,
    localparam int AW            = (G * input_channel > 1) ? $clog2(G * input_channel) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [input_channel*DATA_WIDTH-1:0]    image,
    input  logic [output_channel*DATA_WIDTH-1:0]   bias,
    output logic [AW-1:0]                          w_addr,
    input  logic [PAR*DATA_WIDTH-1:0]              w_data,
    output logic                                   busy,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [output_channel*DATA_WIDTH-1:0]   outputFC
);

    localparam int IW = (input_channel > 1) ? $clog2(input_channel) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int NW = (output_channel > 1) ? $clog2(output_channel) : 1;

    localparam logic [AW-1:0] IC_AW    = AW'(input_channel);
    localparam logic [AW-1:0] IC_M1_AW = AW'(input_channel - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(input_channel - 1);
    localparam logic [GW-1:0] GRP_LAST = GW'(G - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MAC   = 3'd2,
        ST_BIAS  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // FP16 multiply: normal operands only; subnormals flush to zero, round to nearest even.
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic [21:0]       ma;
        logic [21:0]       mb;
        logic [21:0]       p;
        logic [9:0]        f;
        logic              g;
        logic              st;
        logic [10:0]       r;
        logic signed [7:0] e;
        logic [15:0]       res;
        ma = {11'd0, 1'b1, a[9:0]};
        mb = {11'd0, 1'b1, b[9:0]};
        p  = ma * mb;
        e  = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
        if (p[21] == 1'b1) begin
            f  = p[20:11];
            g  = p[10];
            st = |p[9:0];
            e  = e + 8'sd1;
        end else begin
            f  = p[19:10];
            g  = p[9];
            st = |p[8:0];
        end
        r = {1'b0, f} + {10'd0, g & (st | f[0])};
        if (r[10] == 1'b1) begin
            e = e + 8'sd1;
        end else begin
            e = e;
        end
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) begin
            res = {a[15] ^ b[15], 15'd0};
        end else if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) begin
            res = {a[15] ^ b[15], 5'h1f, 10'd0};
        end else if (e >= 8'sd31) begin
            res = {a[15] ^ b[15], 5'h1f, 10'd0};
        end else if (e <= 8'sd0) begin
            res = {a[15] ^ b[15], 15'd0};
        end else begin
            res = {a[15] ^ b[15], e[4:0], r[9:0]};
        end
        return res;
    endfunction

    // FP16 add with guard/round/sticky bits; subnormals flush to zero, exact cancel gives +0.
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0]       x;
        logic [15:0]       y;
        logic [4:0]        d;
        logic [13:0]       mx;
        logic [13:0]       my;
        logic [13:0]       msk;
        logic [14:0]       sm;
        logic              st;
        logic              fnd;
        logic [3:0]        lz;
        logic [10:0]       r;
        logic signed [7:0] e;
        logic [15:0]       res;
        if (a[14:0] >= b[14:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d   = x[14:10] - y[14:10];
        mx  = {1'b1, x[9:0], 3'b000};
        my  = {1'b1, y[9:0], 3'b000};
        msk = 14'd0;
        if (d > 5'd13) begin
            st = 1'b1;
            my = 14'd0;
        end else begin
            msk = (14'd1 << d) - 14'd1;
            st  = |(my & msk);
            my  = my >> d;
        end
        my  = my | {13'd0, st};
        e   = $signed({3'b000, x[14:10]});
        lz  = 4'd0;
        fnd = 1'b0;
        if (x[15] == y[15]) begin
            sm = {1'b0, mx} + {1'b0, my};
            if (sm[14] == 1'b1) begin
                sm = {1'b0, sm[14:2], sm[1] | sm[0]};
                e  = e + 8'sd1;
            end else begin
                sm = sm;
            end
        end else begin
            sm = {1'b0, mx} - {1'b0, my};
            for (int k = 13; k >= 0; k--) begin
                if (fnd == 1'b0 && sm[k] == 1'b1) begin
                    fnd = 1'b1;
                end else if (fnd == 1'b0) begin
                    lz = lz + 4'd1;
                end else begin
                    fnd = fnd;
                end
            end
            sm = sm << lz;
            e  = e - $signed({4'd0, lz});
        end
        r = {1'b0, sm[12:3]} + {10'd0, sm[2] & (sm[1] | sm[0] | sm[3])};
        if (r[10] == 1'b1) begin
            e = e + 8'sd1;
        end else begin
            e = e;
        end
        if (x[14:10] == 5'h1f) begin
            res = x;
        end else if (x[14:10] == 5'd0) begin
            res = {a[15] & b[15], 15'd0};
        end else if (y[14:10] == 5'd0) begin
            res = x;
        end else if (sm == 15'd0) begin
            res = 16'h0000;
        end else if (e >= 8'sd31) begin
            res = {x[15], 5'h1f, 10'd0};
        end else if (e <= 8'sd0) begin
            res = {x[15], 15'd0};
        end else begin
            res = {x[15], e[4:0], r[9:0]};
        end
        return res;
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [GW-1:0]           g_r;
    logic [IW-1:0]           idx_r;
    logic [AW-1:0]           base_r;
    logic [AW-1:0]           w_addr_r;
    logic                    busy_r;
    logic                    out_valid_r;
    logic [DATA_WIDTH-1:0]   acc_r      [PAR];
    logic [DATA_WIDTH-1:0]   image_r    [input_channel];
    logic [DATA_WIDTH-1:0]   out_r      [output_channel];

    logic                    accept_s;
    logic                    clear_s;
    logic                    mac_en_s;
    logic                    bias_en_s;
    logic                    done_s;
    logic                    last_idx_s;
    logic                    last_grp_s;
    logic                    addr_end_s;
    logic [DATA_WIDTH-1:0]   image_arr_s [input_channel];
    logic [DATA_WIDTH-1:0]   bias_arr_s  [output_channel];
    logic [DATA_WIDTH-1:0]   w_lane_s    [PAR];
    logic [DATA_WIDTH-1:0]   mac_res_s   [PAR];
    logic [DATA_WIDTH-1:0]   bias_op_s   [PAR];
    logic [DATA_WIDTH-1:0]   bias_sum_s  [PAR];
    logic [DATA_WIDTH-1:0]   bias_res_s  [PAR];

    for (genvar k = 0; k < input_channel; k++) begin : g_img
        assign image_arr_s[k] = image[k*DATA_WIDTH +: DATA_WIDTH];
    end
    for (genvar n = 0; n < output_channel; n++) begin : g_neuron
        assign bias_arr_s[n]                         = bias[n*DATA_WIDTH +: DATA_WIDTH];
        assign outputFC[n*DATA_WIDTH +: DATA_WIDTH]  = out_r[n];
    end
    for (genvar l = 0; l < PAR; l++) begin : g_lane
        assign w_lane_s[l] = w_data[l*DATA_WIDTH +: DATA_WIDTH];
    end

    assign last_idx_s = (idx_r == IDX_LAST);
    assign last_grp_s = (g_r == GRP_LAST);
    assign addr_end_s = (w_addr_r == base_r + IC_M1_AW);
    assign w_addr     = w_addr_r;
    assign busy       = busy_r;
    assign out_valid  = out_valid_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = start ? ST_FETCH : ST_IDLE;
            ST_FETCH: state_nxt_s = ST_MAC;
            ST_MAC:   state_nxt_s = last_idx_s ? ST_BIAS : ST_MAC;
            ST_BIAS:  state_nxt_s = last_grp_s ? ST_HOLD : ST_FETCH;
            ST_HOLD:  state_nxt_s = out_ready ? ST_IDLE : ST_HOLD;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Per-state control strobes for the datapath.
    always_comb begin
        accept_s  = 1'b0;
        clear_s   = 1'b0;
        mac_en_s  = 1'b0;
        bias_en_s = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE:  accept_s  = start;
            ST_FETCH: clear_s   = 1'b1;
            ST_MAC:   mac_en_s  = 1'b1;
            ST_BIAS:  bias_en_s = 1'b1;
            ST_HOLD:  done_s    = out_ready;
            default:  accept_s  = 1'b0;
        endcase
    end

    // Group/index counters, weight address prefetch and handshake flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            g_r         <= '0;
            idx_r       <= '0;
            base_r      <= '0;
            w_addr_r    <= '0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            busy_r   <= 1'b1;
            g_r      <= '0;
            base_r   <= '0;
            w_addr_r <= '0;
        end else if (clear_s || mac_en_s) begin
            // The address runs one word ahead of the index and parks on the group's last word.
            idx_r <= (clear_s || last_idx_s) ? '0 : idx_r + IW'(1);
            if (!addr_end_s) begin
                w_addr_r <= w_addr_r + AW'(1);
            end
        end else if (bias_en_s) begin
            if (last_grp_s) begin
                out_valid_r <= 1'b1;
            end else begin
                g_r      <= g_r + GW'(1);
                base_r   <= base_r + IC_AW;
                w_addr_r <= base_r + IC_AW;
            end
        end else if (done_s) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end
    end

    // One MAC step per lane: acc + image[i] * weight.
    always_comb begin
        for (int l = 0; l < PAR; l++) begin
            mac_res_s[l] = fp16_add(acc_r[l], fp16_mul(image_r[idx_r], w_lane_s[l]));
        end
    end

    // Bias add and optional ReLU per lane; lanes past the last neuron see a zero bias.
    always_comb begin
        int n;
        n = 0;
        for (int l = 0; l < PAR; l++) begin
            n = int'(g_r) * PAR + l;
            if (n < output_channel) begin
                bias_op_s[l] = bias_arr_s[NW'(n)];
            end else begin
                bias_op_s[l] = '0;
            end
            bias_sum_s[l] = fp16_add(acc_r[l], bias_op_s[l]);
            if (RELU == 1 && bias_sum_s[l][DATA_WIDTH-1] == 1'b1) begin
                bias_res_s[l] = '0;
            end else begin
                bias_res_s[l] = bias_sum_s[l];
            end
        end
    end

    // Image capture, lane accumulators and output vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r   <= '{default: '0};
            image_r <= '{default: '0};
            out_r   <= '{default: '0};
        end else begin
            if (accept_s) begin
                image_r <= image_arr_s;
            end
            for (int l = 0; l < PAR; l++) begin
                if (clear_s) begin
                    acc_r[l] <= '0;
                end else if (mac_en_s) begin
                    acc_r[l] <= mac_res_s[l];
                end
            end
            // Neuron n belongs to group n/PAR, lane n%PAR; masked lanes never match a neuron.
            for (int n = 0; n < output_channel; n++) begin
                if (bias_en_s && (g_r == GW'(n / PAR))) begin
                    out_r[n] <= bias_res_s[n % PAR];
                end
            end
        end
    end

endmodule

// File: doc/fc_layer_tm.md
Name: fc_layer_tm

Overview:
- Time-multiplexed FP16 fully connected layer. It replaces the fully parallel FC layer, which needs one conv unit per output neuron.
- PAR lanes compute PAR output neurons at a time. Each lane does a serial multiply-accumulate over the input channels.
- Weights are read from an external weight ROM, one word per cycle. Bias add and optional ReLU are applied before the result is presented.
- Sits between the flatten/pool stage and the next FC or softmax stage, with a start/busy input side and a valid/ready output side.

Parameters:
- DATA_WIDTH, 16, element width (IEEE half precision).
- input_channel, 120, inputs per neuron.
- output_channel, 84, number of output neurons.
- PAR, 4, parallel MAC lanes (1..output_channel).
- RELU, 0, 1 = clamp negative outputs to +0 after bias.
- Derived, not overridable:
  - G = ceil(output_channel/PAR), number of neuron groups.
  - AW = clog2(G*input_channel), weight address width (minimum 1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  start request, sampled only in IDLE.
- image  in  input_channel*DATA_WIDTH  input vector, element i at [i*DATA_WIDTH +: DATA_WIDTH]; captured on start accept.
- bias  in  output_channel*DATA_WIDTH  bias of neuron n at [n*DATA_WIDTH +: DATA_WIDTH]; must stay stable while busy.
- w_addr  out  AW  weight ROM address.
- w_data  in  PAR*DATA_WIDTH  ROM word, 1-cycle read latency. Lane l at [l*DATA_WIDTH +: DATA_WIDTH] is the weight of neuron g*PAR+l for input i, where address = g*input_channel+i.
- busy  out  1  high from start accept until output handshake completes.
- out_valid  out  1  result vector valid.
- out_ready  in  1  downstream accepts the result.
- outputFC  out  output_channel*DATA_WIDTH  neuron n at [n*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (synchronous): state=IDLE, busy=0, out_valid=0, outputFC=0, w_addr=0, accumulators=+0, group/index counters=0.
- Reset has priority over every other event, including mid-operation. An in-flight computation is discarded with no partial output.
- States: IDLE, FETCH, MAC, BIAS, HOLD.
- IDLE:
  - start=1 latches image, sets busy=1, group g=0, and moves to FETCH.
  - start in any other state is ignored.
- FETCH (1 cycle):
  - drives w_addr=g*input_channel.
  - clears all PAR accumulators to 16'h0000.
  - goes to MAC with index i=0.
- MAC (input_channel cycles):
  - each cycle, acc[l] <= Float16Add(acc[l], Float16Mult(image[i], w_data lane l)).
  - w_addr is driven to g*input_channel+i+1 in the same cycle (prefetch). On the last index it is held.
  - after i=input_channel-1, go to BIAS.
- BIAS (1 cycle):
  - for each lane with n=g*PAR+l < output_channel: outputFC[n] <= acc[l]+bias[n].
  - if RELU=1 and the sum's sign bit=1, store 16'h0000 instead. -0 also maps to +0.
  - lanes with n >= output_channel write nothing.
  - if g=G-1: go to HOLD and set out_valid=1. Otherwise g<=g+1 and go to FETCH.
- HOLD:
  - outputFC and out_valid are held stable.
  - on out_valid&&out_ready, at that edge: out_valid=0, busy=0, state=IDLE.
  - outputFC keeps its last value until the next BIAS write.
- Latency: out_valid is high exactly G*(input_channel+2) rising edges after the start-accept edge.
- Earliest possible handshake is that same cycle. The next start can be accepted at the following edge.
- Arithmetic: FP16 throughout via the team's Float16Mult/Float16Add. No internal widening; rounding is whatever those units produce. Accumulation order is i ascending.
- w_data is sampled in MAC cycles only; its value in other states is don't-care.

Test Plan:
- input_channel=4, output_channel=6, PAR=4, RELU=0; image all 3C00, weights all 3C00, bias 0 -> all six outputs 4400. out_valid high exactly 12 edges after start. w_addr sequence is 0,1,2,3,3 then 4,5,6,7,7.
- Same config; image all 4000, weights all 3800, bias all 4000 -> outputs 4600 (4*1.0+2.0).
- Weights all BC00, image 3C00, bias 0 -> RELU=0 gives C400; RELU=1 gives 0000 for all neurons.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid and pulse start each cycle -> outputFC/out_valid stable, starts ignored. After out_ready=1, busy=0 and out_valid=0 on the same edge.
- Reset asserted mid-MAC of group 0 -> next cycle busy=0, out_valid=0, outputFC=0. A fresh start then yields the correct result with the same 12-edge latency.
- Distinct per-neuron weights (neuron n weight = n+1, image all 3C00, bias 0) -> outputFC[n] = 4*(n+1): 4400,4800,4A00,4C00,4D00,4E00. Confirms the group/lane mapping and the masked lanes 2,3 of group 1.
